output_serializer: RTL and testbench

- Parallel-to-serial counterpart of the TCU input word buffer.
- Captures one DEPTH-word block, e.g. a computed result tile, in a single cycle.
- Streams the block out one DATA_WIDTH word per valid/ready handshake, word 0 first.
- Sits between the TCU result register and the AXI-Stream/DMA egress path, so blocks written by the input buffer's shift order round-trip unchanged.

---
 rtl/tcu_pkg.sv | 13 +
 rtl/output_serializer_if.sv | 28 ++
 rtl/output_serializer.sv | 65 ++++++
 tb/tb_output_serializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcu_pkg.sv
// Shared TCU definitions: serializer FSM encoding and default block geometry,
// also used by the input word buffer.
package tcu_pkg;

    localparam int TCU_DATA_WIDTH  = 32;
    localparam int TCU_BLOCK_DEPTH = 48;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/output_serializer_if.sv
// Block-capture and stream-egress signals of the output serializer.
// The slave modport is the serializer side; master is the producer/consumer side.
interface output_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 48
);
    localparam int CNT_W = $clog2(DEPTH);

    logic                        load;
    logic                        load_ready;
    logic [DEPTH*DATA_WIDTH-1:0] data_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       data_out;
    logic                        out_last;
    logic [CNT_W-1:0]            word_idx;

    modport slave (
        input  load, data_in, out_ready,
        output load_ready, out_valid, data_out, out_last, word_idx
    );

    modport master (
        output load, data_in, out_ready,
        input  load_ready, out_valid, data_out, out_last, word_idx
    );

endinterface

// File: rtl/output_serializer.sv
// Captures a DEPTH-word block in one cycle and streams it out word 0 first,
// one word per valid/ready handshake.
module output_serializer
    import tcu_pkg::*;
#(
    parameter int DATA_WIDTH = TCU_DATA_WIDTH,
    parameter int DEPTH      = TCU_BLOCK_DEPTH
) (
    input logic               clk,
    input logic               rst,
    output_serializer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int BLK_W = DEPTH * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SEND = SEND;

    logic [0:0]       state;
    logic [BLK_W-1:0] shreg;
    logic [CNT_W-1:0] idx;

    // The head word always sits in the low slot; emptying the register on the
    // final handshake is what returns data_out to zero in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        shreg <= bus.data_in;
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            shreg <= '0;
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            shreg <= {{DATA_WIDTH{1'b0}}, shreg[BLK_W-1:DATA_WIDTH]};
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_SEND);
    assign bus.data_out   = shreg[DATA_WIDTH-1:0];
    assign bus.word_idx   = idx;
    assign bus.out_last   = (state == ST_SEND) && (idx == LAST_IDX);

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer at DEPTH 48, 4 (round-trip) and 2.
module tb_output_serializer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    output_serializer_if #(.DATA_WIDTH(32), .DEPTH(48)) if48 ();
    output_serializer_if #(.DATA_WIDTH(32), .DEPTH(4))  if4 ();
    output_serializer_if #(.DATA_WIDTH(32), .DEPTH(2))  if2 ();

    output_serializer #(.DATA_WIDTH(32), .DEPTH(48)) dut48 (.clk(clk), .rst(rst), .bus(if48));
    output_serializer #(.DATA_WIDTH(32), .DEPTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    output_serializer #(.DATA_WIDTH(32), .DEPTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_load_ready got=%b exp=1", if48.load_ready); end
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b exp=0", if48.out_valid); end
        n_cmp++; if (if48.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last got=%b exp=0", if48.out_last); end
        n_cmp++; if (if48.data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data_out got=%h exp=0", if48.data_out); end
        n_cmp++; if (if48.word_idx !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_word_idx got=%0d exp=0", if48.word_idx); end
        rst = 1'b1;
    endtask

    task automatic test_basic_stream();
        @(negedge clk);
        for (int i = 0; i < 48; i++) if48.data_in[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        if48.load = 1'b1;
        if48.out_ready = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        for (int k = 0; k < 48; k++) begin
            n_cmp++; if (if48.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid k=%0d got=%b exp=1", k, if48.out_valid); end
            n_cmp++; if (if48.data_out !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("[TB] FAIL basic_data k=%0d got=%h exp=%h", k, if48.data_out, 32'h1000_0000 + 32'(k)); end
            n_cmp++; if (if48.word_idx !== 6'(k)) begin n_fail++; $display("[TB] FAIL basic_idx k=%0d got=%0d exp=%0d", k, if48.word_idx, k); end
            n_cmp++; if (if48.out_last !== (k == 47)) begin n_fail++; $display("[TB] FAIL basic_last k=%0d got=%b exp=%b", k, if48.out_last, (k == 47)); end
            n_cmp++; if (if48.load_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy k=%0d got=%b exp=0", k, if48.load_ready); end
            @(negedge clk);
        end
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_end_valid got=%b exp=0", if48.out_valid); end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_end_ready got=%b exp=1", if48.load_ready); end
        n_cmp++; if (if48.data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL basic_end_data got=%h exp=0", if48.data_out); end
        n_cmp++; if (if48.word_idx !== 6'd0) begin n_fail++; $display("[TB] FAIL basic_end_idx got=%0d exp=0", if48.word_idx); end
        n_cmp++; if (if48.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_end_last got=%b exp=0", if48.out_last); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pat;
        logic        r;
        int          k;
        int          cyc;
        pat = 32'b1011_0010_0111_0001_1100_1010_0110_1101;
        k = 0;
        cyc = 0;
        if48.out_ready = 1'b0;
        if48.load = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        while (k < 48 && cyc < 400) begin
            n_cmp++; if (if48.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid k=%0d got=%b exp=1", k, if48.out_valid); end
            n_cmp++; if (if48.data_out !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("[TB] FAIL bp_data k=%0d cyc=%0d got=%h exp=%h", k, cyc, if48.data_out, 32'h1000_0000 + 32'(k)); end
            n_cmp++; if (if48.word_idx !== 6'(k)) begin n_fail++; $display("[TB] FAIL bp_idx k=%0d got=%0d exp=%0d", k, if48.word_idx, k); end
            n_cmp++; if (if48.out_last !== (k == 47)) begin n_fail++; $display("[TB] FAIL bp_last k=%0d got=%b exp=%b", k, if48.out_last, (k == 47)); end
            r = pat[cyc % 32];
            if48.out_ready = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        n_cmp++; if (k != 48) begin n_fail++; $display("[TB] FAIL bp_timeout handshakes got=%0d exp=48", k); end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_end_ready got=%b exp=1", if48.load_ready); end
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_end_valid got=%b exp=0", if48.out_valid); end
    endtask

    task automatic test_load_while_busy();
        if48.out_ready = 1'b1;
        if48.load = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        for (int k = 0; k < 48; k++) begin
            n_cmp++; if (if48.data_out !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("[TB] FAIL busy_data k=%0d got=%h exp=%h", k, if48.data_out, 32'h1000_0000 + 32'(k)); end
            n_cmp++; if (if48.word_idx !== 6'(k)) begin n_fail++; $display("[TB] FAIL busy_idx k=%0d got=%0d exp=%0d", k, if48.word_idx, k); end
            if (k == 5) begin
                for (int i = 0; i < 48; i++) if48.data_in[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
                if48.load = 1'b1;
            end
            if (k == 6) if48.load = 1'b0;
            if (k == 47) if48.load = 1'b1;
            @(negedge clk);
        end
        if48.load = 1'b0;
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_final_load_valid got=%b exp=0", if48.out_valid); end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_final_load_ready got=%b exp=1", if48.load_ready); end
        if48.load = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        for (int k = 0; k < 48; k++) begin
            n_cmp++; if (if48.data_out !== 32'hDEAD_0000 + 32'(k)) begin n_fail++; $display("[TB] FAIL busy_new_data k=%0d got=%h exp=%h", k, if48.data_out, 32'hDEAD_0000 + 32'(k)); end
            n_cmp++; if (if48.out_last !== (k == 47)) begin n_fail++; $display("[TB] FAIL busy_new_last k=%0d got=%b exp=%b", k, if48.out_last, (k == 47)); end
            @(negedge clk);
        end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_new_end got=%b exp=1", if48.load_ready); end
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 48; i++) if48.data_in[i*32 +: 32] = 32'h2000_0000 + 32'(i);
        if48.out_ready = 1'b1;
        if48.load = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk);
        n_cmp++; if (if48.word_idx !== 6'd20) begin n_fail++; $display("[TB] FAIL rstmid_pre_idx got=%0d exp=20", if48.word_idx); end
        n_cmp++; if (if48.data_out !== 32'h2000_0014) begin n_fail++; $display("[TB] FAIL rstmid_pre_data got=%h exp=20000014", if48.data_out); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid got=%b exp=0", if48.out_valid); end
        n_cmp++; if (if48.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_last got=%b exp=0", if48.out_last); end
        n_cmp++; if (if48.data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_data got=%h exp=0", if48.data_out); end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready got=%b exp=1", if48.load_ready); end
        n_cmp++; if (if48.word_idx !== 6'd0) begin n_fail++; $display("[TB] FAIL rstmid_idx got=%0d exp=0", if48.word_idx); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (if48.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_abandon got=%b exp=0", if48.out_valid); end
        for (int i = 0; i < 48; i++) if48.data_in[i*32 +: 32] = 32'h3000_0000 + 32'(i);
        if48.load = 1'b1;
        @(negedge clk);
        if48.load = 1'b0;
        for (int k = 0; k < 48; k++) begin
            n_cmp++; if (if48.data_out !== 32'h3000_0000 + 32'(k)) begin n_fail++; $display("[TB] FAIL rstmid_new_data k=%0d got=%h exp=%h", k, if48.data_out, 32'h3000_0000 + 32'(k)); end
            n_cmp++; if (if48.word_idx !== 6'(k)) begin n_fail++; $display("[TB] FAIL rstmid_new_idx k=%0d got=%0d exp=%0d", k, if48.word_idx, k); end
            @(negedge clk);
        end
        n_cmp++; if (if48.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_new_end got=%b exp=1", if48.load_ready); end
    endtask

    task automatic test_round_trip();
        logic [127:0] blk;
        logic [127:0] ibuf;
        logic         r;
        int           hs_n;
        int           cyc;
        blk  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        ibuf = '0;
        hs_n = 0;
        cyc  = 0;
        @(negedge clk);
        if4.data_in = blk;
        if4.load = 1'b1;
        @(negedge clk);
        if4.load = 1'b0;
        // Input-buffer model: each accepted word enters at the top and shifts down.
        while (hs_n < 4 && cyc < 30) begin
            r = (cyc % 3 != 1);
            if4.out_ready = r;
            if (r && if4.out_valid) begin
                ibuf = {if4.data_out, ibuf[127:32]};
                hs_n++;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (hs_n != 4) begin n_fail++; $display("[TB] FAIL rt_handshakes got=%0d exp=4", hs_n); end
        n_cmp++; if (ibuf !== blk) begin n_fail++; $display("[TB] FAIL rt_block got=%h exp=%h", ibuf, blk); end
        n_cmp++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rt_end_valid got=%b exp=0", if4.out_valid); end
        n_cmp++; if (if4.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rt_end_ready got=%b exp=1", if4.load_ready); end
    endtask

    task automatic test_min_depth();
        @(negedge clk);
        if2.data_in = {32'h0000_0002, 32'h0000_0001};
        if2.out_ready = 1'b1;
        if2.load = 1'b1;
        @(negedge clk);
        if2.load = 1'b0;
        n_cmp++; if (if2.data_out !== 32'h1) begin n_fail++; $display("[TB] FAIL min_data0 got=%h exp=1", if2.data_out); end
        n_cmp++; if (if2.word_idx !== 1'b0) begin n_fail++; $display("[TB] FAIL min_idx0 got=%0d exp=0", if2.word_idx); end
        n_cmp++; if (if2.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL min_last0 got=%b exp=0", if2.out_last); end
        n_cmp++; if (if2.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL min_valid0 got=%b exp=1", if2.out_valid); end
        @(negedge clk);
        n_cmp++; if (if2.data_out !== 32'h2) begin n_fail++; $display("[TB] FAIL min_data1 got=%h exp=2", if2.data_out); end
        n_cmp++; if (if2.word_idx !== 1'b1) begin n_fail++; $display("[TB] FAIL min_idx1 got=%0d exp=1", if2.word_idx); end
        n_cmp++; if (if2.out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL min_last1 got=%b exp=1", if2.out_last); end
        @(negedge clk);
        n_cmp++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL min_end_valid got=%b exp=0", if2.out_valid); end
        n_cmp++; if (if2.load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL min_end_ready got=%b exp=1", if2.load_ready); end
        n_cmp++; if (if2.data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL min_end_data got=%h exp=0", if2.data_out); end
        n_cmp++; if (if2.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL min_end_last got=%b exp=0", if2.out_last); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        if48.load = 1'b0; if48.out_ready = 1'b0; if48.data_in = '0;
        if4.load  = 1'b0; if4.out_ready  = 1'b0; if4.data_in  = '0;
        if2.load  = 1'b0; if2.out_ready  = 1'b0; if2.data_in  = '0;
        $display("[TB] starting output_serializer bench");
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_load_while_busy();
        test_reset_mid_stream();
        test_round_trip();
        test_min_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
